// File: rtl/sbox_iter_ctrl.sv
// sbox_iter_ctrl: iterative S-box sequencer.
// Takes one value per request and feeds it through an external combinational
// S-box iter_num times. The intermediate value lives in val_q and loops back
// to the S-box input. The result is returned over a valid/ready handshake.
// Optional build macro SBOX_ITER_CLR_EN: scrub the value register after
// consume/flush and hold the S-box input at zero while idle.
module sbox_iter_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value_in,
  input  logic [CNT_W-1:0] iter_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value_out,
  output logic [WIDTH-1:0] sbox_in,
  input  logic [WIDTH-1:0] sbox_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             accept;
  logic [CNT_W-1:0] cntInc;

  // Handshake signals, status flags and the S-box input mux.
  // While reset is asserted no accept can happen, so the mux shows val_q
  // (which is zero) and the S-box input stays quiet.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept    = in_valid && in_ready && rst;
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
    value_out = val_q;
    cntInc    = cnt_q + 1'b1;
    if (accept) begin
      sbox_in = value_in;
    end else begin
      sbox_in = val_q;
    end
`ifdef SBOX_ITER_CLR_EN
    if ((state_q == IDLE) && !in_valid) begin
      sbox_in = '0;
    end
`endif
  end

  // Next-state logic: flush beats everything, then accept/iterate/hold rules.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef SBOX_ITER_CLR_EN
      val_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (iter_num == '0) begin
              val_d   = value_in;
              state_d = DONE;
            end else if (iter_num == CNT_W'(1)) begin
              val_d   = sbox_out;
              cnt_d   = CNT_W'(1);
              state_d = DONE;
            end else begin
              val_d   = sbox_out;
              cnt_d   = CNT_W'(1);
              tgt_d   = iter_num;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          val_d = sbox_out;
          cnt_d = cntInc;
          if (cntInc == tgt_q) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (accept) begin
              if (iter_num == '0) begin
                val_d   = value_in;
                state_d = DONE;
              end else if (iter_num == CNT_W'(1)) begin
                val_d   = sbox_out;
                cnt_d   = CNT_W'(1);
                state_d = DONE;
              end else begin
                val_d   = sbox_out;
                cnt_d   = CNT_W'(1);
                tgt_d   = iter_num;
                state_d = RUN;
              end
            end else begin
              state_d = IDLE;
`ifdef SBOX_ITER_CLR_EN
              val_d   = '0;
`endif
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: tb/tb_sbox_iter_ctrl.sv
// Testbench for sbox_iter_ctrl with an AES S-box attached to the S-box port.
// A transaction-level reference model computes each result as S^N(value)
// and its latency as max(N,1) cycles. Directed cases come first, then random traffic.
module tb_sbox_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] value_in;
  logic [3:0] iter_num;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] value_out;
  logic [7:0] sbox_in;
  logic [7:0] sbox_out;
  logic       busy;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state: cycles still to go, pending result, and whether
  // the value register should read as scrubbed to zero.
  int         mLeft;
  logic       mValid;
  logic [7:0] mResult;
  logic       mCleared;

  logic [0:255][7:0] aesTable = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign sbox_out = aesTable[sbox_in];

  sbox_iter_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value_in  (value_in),
    .iter_num  (iter_num),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .value_out (value_out),
    .sbox_in   (sbox_in),
    .sbox_out  (sbox_out),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Apply the S-box n times to v.
  function automatic logic [7:0] sboxIter(input logic [7:0] v, input logic [3:0] n);
    logic [7:0] s;
    s = v;
    for (int i = 0; i < int'(n); i++) begin
      s = aesTable[s];
    end
    return s;
  endfunction

  // Count one comparison and report it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    mLeft    = 0;
    mValid   = 1'b0;
    mResult  = 8'h00;
    mCleared = 1'b1;
  endtask

  // Drive one cycle of inputs, check combinational outputs, advance the
  // model across the clock edge, then check registered outputs.
  task automatic applyStimulus(input logic v, input logic [7:0] val, input logic [3:0] n,
                               input logic ordy, input logic fl);
    logic expReady;
    int   lat;
    in_valid  = v;
    value_in  = val;
    iter_num  = n;
    out_ready = ordy;
    flush     = fl;
    #1;
    expReady = (mLeft == 0) && (!mValid || ordy);
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    if (v && expReady) begin
      checkOutput("sbox_in_accept", 32'(sbox_in), 32'(val));
    end
`ifdef SBOX_ITER_CLR_EN
    if (!v && mLeft == 0 && !mValid) begin
      checkOutput("sbox_in_idle_zero", 32'(sbox_in), 32'h0);
    end
`endif
    @(posedge clk);
    if (fl) begin
      mLeft    = 0;
      mValid   = 1'b0;
      mCleared = 1'b1;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin
        mValid = 1'b1;
      end
    end else if (mValid && !ordy) begin
      mValid = 1'b1;
    end else begin
      if (mValid) begin
        mValid   = 1'b0;
        mCleared = 1'b1;
      end
      if (v) begin
        mResult  = sboxIter(val, n);
        lat      = (n == 4'd0) ? 1 : int'(n);
        mLeft    = lat - 1;
        mValid   = (mLeft == 0);
        mCleared = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("busy", 32'(busy), 32'(mLeft > 0));
    if (mValid) begin
      checkOutput("value_out", 32'(value_out), 32'(mResult));
    end
`ifdef SBOX_ITER_CLR_EN
    if (mCleared) begin
      checkOutput("value_out_scrubbed", 32'(value_out), 32'h0);
    end
`endif
  endtask

  task automatic idleCycles(input int count, input logic ordy);
    for (int i = 0; i < count; i++) begin
      applyStimulus(1'b0, 8'h00, 4'd0, ordy, 1'b0);
    end
  endtask

  // Outputs that must show reset values whenever reset is asserted.
  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_in_ready"}, 32'(in_ready), 32'h1);
    checkOutput({phase, "_out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({phase, "_busy"}, 32'(busy), 32'h0);
    checkOutput({phase, "_value_out"}, 32'(value_out), 32'h0);
    checkOutput({phase, "_sbox_in"}, 32'(sbox_in), 32'h0);
  endtask

  initial begin
    logic       rv, rr, rf;
    logic [7:0] rval;
    logic [3:0] rn;

    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    value_in  = 8'h00;
    iter_num  = 4'd0;
    out_ready = 1'b0;
    resetModel();
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b1;

    // Single S-box pass: S(0x00) = 0x63 one cycle after accept.
    applyStimulus(1'b1, 8'h00, 4'd1, 1'b1, 1'b0);
    checkOutput("t1_value", 32'(value_out), 32'h63);
    idleCycles(1, 1'b1);

    // Three passes: 0x63, 0xFB, 0x0F; busy for two cycles, result on the third.
    applyStimulus(1'b1, 8'h00, 4'd3, 1'b0, 1'b0);
    checkOutput("t2_busy_c1", 32'(busy), 32'h1);
    idleCycles(2, 1'b0);
    checkOutput("t2_value", 32'(value_out), 32'h0F);

    // Hold in DONE with out_ready low: result and valid must stay put.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h11, 4'd1, 1'b0, 1'b0);
      checkOutput("t5_hold_value", 32'(value_out), 32'h0F);
    end
    idleCycles(2, 1'b1);

    // Pass-through with zero iterations.
    applyStimulus(1'b1, 8'hA5, 4'd0, 1'b1, 1'b0);
    checkOutput("t3_value", 32'(value_out), 32'hA5);
    idleCycles(1, 1'b1);

    // Back-to-back single-pass requests with no bubble.
    applyStimulus(1'b1, 8'h00, 4'd1, 1'b1, 1'b0);
    checkOutput("t4_first", 32'(value_out), 32'h63);
    applyStimulus(1'b1, 8'h63, 4'd1, 1'b1, 1'b0);
    checkOutput("t4_second", 32'(value_out), 32'hFB);
    idleCycles(1, 1'b1);

    // Flush in the middle of a long run: back to idle, no result.
    applyStimulus(1'b1, 8'h00, 4'd15, 1'b1, 1'b0);
    idleCycles(3, 1'b1);
    applyStimulus(1'b1, 8'h22, 4'd2, 1'b1, 1'b1);
    checkOutput("t6_flush_valid", 32'(out_valid), 32'h0);
    checkOutput("t6_flush_busy", 32'(busy), 32'h0);
    idleCycles(3, 1'b1);

    // Flush coinciding with an accept from DONE: the request is dropped.
    applyStimulus(1'b1, 8'h00, 4'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h55, 4'd2, 1'b1, 1'b1);
    idleCycles(3, 1'b1);

    // Asynchronous reset in the middle of a run.
    applyStimulus(1'b1, 8'h3C, 4'd15, 1'b1, 1'b0);
    idleCycles(2, 1'b1);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checkResetOutputs("midrun_reset");
    resetModel();
    @(negedge clk);
    rst = 1'b1;
    idleCycles(1, 1'b1);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rv   = ($urandom_range(0, 3) != 0);
      rval = 8'($urandom_range(0, 255));
      rn   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      rr   = ($urandom_range(0, 9) < 7);
      rf   = ($urandom_range(0, 39) == 0);
      applyStimulus(rv, rval, rn, rr, rf);
    end
    idleCycles(20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
